// File: rtl/x1_multiplier.sv
// rtl/x1_multiplier.sv - multiplier X1 stage: 5:2 carry-save reduction into the X1X2 FIFO
//
// Ports:
//   clk             core clock, rising edge
//   reset_n         asynchronous active-low reset
//   RES_RX0         X0 head partial sums {v4,v3,v2,v1,v0}, 64 bits each
//   SELECT_MSB_RX0  X0 head: upper half of product wanted
//   SIGNED_RES_RX0  X0 head: sign-correction flag
//   X0X1_EMPTY_SX0  X0 FIFO empty
//   X0X1_POP_SX1    pop X0 FIFO (combinational)
//   X1X2_POP_SX2    X2 pops the X1X2 head
//   RES_RX1         X1X2 head {c1 carry [127:64], c0 sum [63:0]}
//   SELECT_MSB_RX1  X1X2 head flag
//   SIGNED_RES_RX1  X1X2 head flag
//   X1X2_EMPTY_SX1  X1X2 FIFO empty
module x1_multiplier #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [319:0] RES_RX0,
  input  logic         SELECT_MSB_RX0,
  input  logic         SIGNED_RES_RX0,
  input  logic         X0X1_EMPTY_SX0,
  output logic         X0X1_POP_SX1,
  input  logic         X1X2_POP_SX2,
  output logic [127:0] RES_RX1,
  output logic         SELECT_MSB_RX1,
  output logic         SIGNED_RES_RX1,
  output logic         X1X2_EMPTY_SX1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // 3:2 compressor; returns {carry, sum}. Carry is shifted left one place
  // and the bit leaving position 63 is dropped (mod 2^64 arithmetic).
  function automatic logic [127:0] csa(input logic [63:0] a,
                                       input logic [63:0] b,
                                       input logic [63:0] c);
    logic [63:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return {maj[62:0], 1'b0, a ^ b ^ c};
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [127:0] stage_a;
  logic [127:0] stage_b;
  logic [127:0] stage_c;

  assign stage_a = csa(RES_RX0[63:0],    RES_RX0[127:64],  RES_RX0[191:128]);
  assign stage_b = csa(stage_a[63:0],    stage_a[127:64],  RES_RX0[255:192]);
  assign stage_c = csa(stage_b[63:0],    stage_b[127:64],  RES_RX0[319:256]);

  logic [129:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full FIFO blocks the push even when X2 frees a slot this cycle, so the
  // pop request never depends combinationally on X1X2_POP_SX2.
  assign push = ~(full | X0X1_EMPTY_SX0);
  assign pop  = X1X2_POP_SX2 & ~empty;

  assign X0X1_POP_SX1 = push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {SELECT_MSB_RX0, SIGNED_RES_RX0, stage_c};
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic [129:0] head;
  assign head = mem[rd_ptr];

  assign RES_RX1        = head[127:0];
  assign SIGNED_RES_RX1 = head[128];
  assign SELECT_MSB_RX1 = head[129];
  assign X1X2_EMPTY_SX1 = empty;

endmodule
